// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters: grant, one-cycle strobe, wait for MEMDONE.
// Optional WAIT-state timeout is built when MEM_TIMEOUT_EN is defined.
module mem_rr_arbiter #(
    parameter int WA      = 32,
    parameter int WD      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [WA-1:0] ADDR0,
    input  logic [WA-1:0] ADDR1,
    input  logic [WD-1:0] WDATA0,
    input  logic [WD-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [WD-1:0] RDATA0,
    output logic [WD-1:0] RDATA1,
    output logic          ERR,
    output logic [WA-1:0] MEMA,
    output logic          MEMRE,
    output logic          MEMWE,
    output logic [WD-1:0] MEMD,
    input  logic [WD-1:0] MEMQ,
    input  logic          MEMBUSY,
    input  logic          MEMDONE,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_rr_arbiter: TIMEOUT must be at least 1");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          r_gsel;
    logic          r_we;
    logic [WA-1:0] r_addr;
    logic [WD-1:0] r_wdata;

    logic          w_grant_sel;
    logic          w_grant;
    logic          w_issue;
    logic          w_done;
    logic          w_tout;

    assign o_dbg_state = r_state;

    // On a tie the requester that did not win last time gets the port.
    assign w_grant_sel = (REQ0 && REQ1) ? ~r_last : REQ1;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? 16 : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT && !MEMDONE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (REQ0 || REQ1) w_state_nxt = S_ISSUE;
            S_ISSUE: if (!MEMBUSY) w_state_nxt = S_WAIT;
            S_WAIT:  if (MEMDONE || w_tout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant = (r_state == S_IDLE) && (REQ0 || REQ1);
        w_issue = (r_state == S_ISSUE) && !MEMBUSY;
        w_done  = (r_state == S_WAIT) && MEMDONE;
`ifdef MEM_TIMEOUT_EN
        // MEMDONE in the timeout cycle is a normal completion.
        w_tout  = (r_state == S_WAIT) && !MEMDONE && (r_cnt == TO_LAST);
`else
        w_tout  = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last  <= 1'b1;
            r_gsel  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            MEMA    <= '0;
            MEMD    <= '0;
            MEMRE   <= 1'b0;
            MEMWE   <= 1'b0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            RDATA0  <= '0;
            RDATA1  <= '0;
            ERR     <= 1'b0;
        end else begin
            MEMRE <= 1'b0;
            MEMWE <= 1'b0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            ERR   <= 1'b0;
            if (w_grant) begin
                r_gsel  <= w_grant_sel;
                r_we    <= w_grant_sel ? WE1 : WE0;
                r_addr  <= w_grant_sel ? ADDR1 : ADDR0;
                r_wdata <= w_grant_sel ? WDATA1 : WDATA0;
            end
            if (w_issue) begin
                MEMA  <= r_addr;
                MEMD  <= r_wdata;
                MEMWE <= r_we;
                MEMRE <= ~r_we;
            end
            if (w_done || w_tout) begin
                r_last <= r_gsel;
                ERR    <= w_tout;
                if (r_gsel) begin
                    ACK1 <= 1'b1;
                    if (!r_we) RDATA1 <= w_done ? MEMQ : '0;
                end else begin
                    ACK0 <= 1'b1;
                    if (!r_we) RDATA0 <= w_done ? MEMQ : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: transaction table plus hand-written reset, stray-done and timeout sequences.
module tb_mem_rr_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0, REQ1, WE0, WE1;
    logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
    logic        ACK0, ACK1, ERR, MEMRE, MEMWE, MEMBUSY, MEMDONE;
    logic [31:0] RDATA0, RDATA1, MEMA, MEMD, MEMQ;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_rr_arbiter #(.WA(32), .WD(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1), .ERR(ERR),
        .MEMA(MEMA), .MEMRE(MEMRE), .MEMWE(MEMWE), .MEMD(MEMD), .MEMQ(MEMQ),
        .MEMBUSY(MEMBUSY), .MEMDONE(MEMDONE), .o_dbg_state(o_dbg_state)
    );

    typedef struct {
        logic        req0, req1, we0, we1;
        logic [31:0] addr0, addr1, wdata0, wdata1, memq;
        int          busy, dly;
        logic        exp_port;
        logic [31:0] exp_mema, exp_memd;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        drop;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        REQ0 = v.req0; REQ1 = v.req1; WE0 = v.we0; WE1 = v.we1;
        ADDR0 = v.addr0; ADDR1 = v.addr1; WDATA0 = v.wdata0; WDATA1 = v.wdata1;
        MEMBUSY = (v.busy != 0);
        step();
        chk($sformatf("v%0d_issue_state", idx), 64'(o_dbg_state), 64'd1);
        for (int i = 0; i < v.busy; i++) begin
            chk($sformatf("v%0d_busy_strobe", idx), 64'({MEMRE, MEMWE}), 64'd0);
            step();
        end
        MEMBUSY = 1'b0;
        step();
        chk($sformatf("v%0d_memre", idx), 64'(MEMRE), 64'(!v.exp_we));
        chk($sformatf("v%0d_memwe", idx), 64'(MEMWE), 64'(v.exp_we));
        chk($sformatf("v%0d_mema", idx), 64'(MEMA), 64'(v.exp_mema));
        chk($sformatf("v%0d_memd", idx), 64'(MEMD), 64'(v.exp_memd));
        for (int d = 0; d < v.dly; d++) begin
            step();
            chk($sformatf("v%0d_wait_strobe", idx), 64'({MEMRE, MEMWE}), 64'd0);
            chk($sformatf("v%0d_wait_ack", idx), 64'({ACK0, ACK1}), 64'd0);
        end
        MEMDONE = 1'b1;
        MEMQ = v.memq;
        step();
        MEMDONE = 1'b0;
        MEMQ = $urandom;
        chk($sformatf("v%0d_ack0", idx), 64'(ACK0), 64'(v.exp_port == 1'b0));
        chk($sformatf("v%0d_ack1", idx), 64'(ACK1), 64'(v.exp_port == 1'b1));
        chk($sformatf("v%0d_rdata", idx), 64'(v.exp_port ? RDATA1 : RDATA0), 64'(v.exp_rdata));
        chk($sformatf("v%0d_err", idx), 64'(ERR), 64'd0);
        chk($sformatf("v%0d_idle", idx), 64'(o_dbg_state), 64'd0);
        if (v.drop) begin
            REQ0 = 1'b0;
            REQ1 = 1'b0;
            step();
            chk($sformatf("v%0d_ack_pulse", idx), 64'({ACK0, ACK1}), 64'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
        chk({tag, "_mema"}, 64'(MEMA), 64'd0);
        chk({tag, "_memd"}, 64'(MEMD), 64'd0);
        chk({tag, "_strobes"}, 64'({MEMRE, MEMWE}), 64'd0);
        chk({tag, "_acks"}, 64'({ACK0, ACK1, ERR}), 64'd0);
        chk({tag, "_rdata0"}, 64'(RDATA0), 64'd0);
        chk({tag, "_rdata1"}, 64'(RDATA1), 64'd0);
    endtask

    initial begin
        //         req0 req1 we0 we1 addr0  addr1  wdata0  wdata1 memq          busy dly port mema   memd    we  rdata        drop
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0,    32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 32'h10,  32'h0,    1'b0, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h20,  32'h0,    32'h55, 32'h12345678, 4, 1, 1'b1, 32'h20,  32'h55,   1'b1, 32'h0,        1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0,    32'hA,  32'h11111111, 0, 2, 1'b0, 32'h100, 32'h0,    1'b0, 32'h11111111, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0,    32'hA,  32'h22222222, 0, 2, 1'b1, 32'h200, 32'hA,    1'b0, 32'h22222222, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 32'hCAFE, 32'hB,  32'h99999999, 0, 2, 1'b0, 32'h104, 32'hCAFE, 1'b1, 32'h11111111, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 32'hCAFE, 32'hB,  32'h33333333, 0, 2, 1'b1, 32'h204, 32'hB,    1'b0, 32'h33333333, 1'b1};

        RST = 1'b1; REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
        MEMQ = 0; MEMBUSY = 0; MEMDONE = 0;
        step();
        step();
        chk_all_zero("reset");
        RST = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Stray MEMDONE in IDLE, then in ISSUE while busy.
        MEMDONE = 1'b1;
        step();
        chk("stray_idle_ack", 64'({ACK0, ACK1}), 64'd0);
        chk("stray_idle_state", 64'(o_dbg_state), 64'd0);
        MEMDONE = 1'b0;
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h30; MEMBUSY = 1'b1;
        step();
        MEMDONE = 1'b1;
        step();
        chk("stray_issue_ack", 64'({ACK0, ACK1}), 64'd0);
        chk("stray_issue_state", 64'(o_dbg_state), 64'd1);
        MEMDONE = 1'b0; MEMBUSY = 1'b0;
        step();
        chk("stray_strobe", 64'({MEMRE, MEMA}), {31'd0, 1'b1, 32'h30});
        MEMDONE = 1'b1; MEMQ = 32'hABCD0123;
        step();
        MEMDONE = 1'b0; REQ0 = 1'b0;
        chk("stray_final_ack", 64'({ACK0, ACK1}), 64'b10);
        chk("stray_final_rdata", 64'(RDATA0), 64'hABCD0123);
        step();

        // Reset in WAIT; last winner was 0 so only reset can make 0 win the next tie.
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h44;
        step();
        step();
        chk("rst_pre_strobe", 64'(MEMRE), 64'd1);
        RST = 1'b1; REQ1 = 1'b0;
        step();
        RST = 1'b0;
        chk_all_zero("rst_mid");
        MEMDONE = 1'b1; MEMQ = 32'h5A5A5A5A;
        step();
        MEMDONE = 1'b0;
        chk("rst_late_done_ack", 64'({ACK0, ACK1}), 64'd0);
        REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h50;
        step();
        step();
        chk("rst_first_grant_mema", 64'(MEMA), 64'h50);
        MEMDONE = 1'b1; MEMQ = 32'h0F0F0F0F;
        step();
        MEMDONE = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        chk("rst_first_grant_ack", 64'({ACK0, ACK1}), 64'b10);
        chk("rst_first_grant_rdata", 64'(RDATA0), 64'h0F0F0F0F);
        step();

`ifdef MEM_TIMEOUT_EN
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h40;
        step();
        step();
        REQ0 = 1'b0;
        chk("to_strobe", 64'(MEMRE), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("to_wait%0d_ack", c), 64'({ACK0, ERR}), 64'd0);
        end
        step();
        chk("to_ack_err", 64'({ACK0, ACK1, ERR}), 64'b101);
        chk("to_rdata", 64'(RDATA0), 64'd0);
        chk("to_idle", 64'(o_dbg_state), 64'd0);
        step();
        chk("to_err_pulse", 64'(ERR), 64'd0);
`else
        // Without the timeout, a read with no MEMDONE just waits.
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h40;
        step();
        step();
        REQ0 = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("noto_still_wait", 64'(o_dbg_state), 64'd2);
        chk("noto_no_ack", 64'({ACK0, ACK1, ERR}), 64'd0);
        MEMDONE = 1'b1; MEMQ = 32'h77;
        step();
        MEMDONE = 1'b0;
        chk("noto_late_ack", 64'({ACK0, ACK1, ERR}), 64'b100);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
